// File: rtl/mp64_dma_arb.sv
// N-channel byte DMA arbiter onto a single 64-bit memory request port.
// Round-robin or fixed priority, optional grant hold, per-transfer timeout.
module mp64_dma_arb #(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 64,
    parameter int PRIO_MODE = 0,
    parameter int HOLD      = 1,
    parameter int TIMEOUT   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    input  logic [NCH*8-1:0]      ch_wdata,
    input  logic [NCH-1:0]        ch_wen,
    output logic [7:0]            ch_rdata,
    output logic [NCH-1:0]        ch_ack,
    output logic [NCH-1:0]        ch_err,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [63:0]           mem_wdata,
    output logic                  mem_wen,
    output logic [1:0]            mem_size,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD - 1);

    typedef enum logic [1:0] {ARB, ISSUE, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [TW-1:0]       wait_q, wait_d;
    logic                err_q, err_d;
    logic                prev_q, prev_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                mem_wen_q, mem_wen_d;
    logic [NCH-1:0]      ch_ack_q, ch_ack_d;
    logic [NCH-1:0]      ch_err_q, ch_err_d;
    logic [7:0]          ch_rdata_q, ch_rdata_d;

    logic                found;
    logic [2:0]          win;
    logic [2:0]          gsel;
    logic                req_g;
    logic                hold_ok;
    logic [NCH-1:0]      gmask;
    logic [ADDR_W-1:0]   addr_sel;
    logic [7:0]          wdata_sel;
    logic                wen_sel;
    int                  j;
    logic                unused_rdata;

    assign unused_rdata = ^mem_rdata[63:8];

    // Arbitration winner, ignoring hold
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        if (PRIO_MODE != 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (ch_req[i]) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                j = (int'(ptr_q) + k) % NCH;
                for (int i = 0; i < NCH; i++) begin
                    if (i == j && !found && ch_req[i]) begin
                        found = 1'b1;
                        win   = 3'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        req_g = 1'b0;
        gmask = '0;
        for (int i = 0; i < NCH; i++) begin
            if (3'(i) == grant_q) begin
                req_g    = ch_req[i];
                gmask[i] = 1'b1;
            end
        end
    end

    // Timed-out transfers lose their hold so a stuck channel cannot starve others
    assign hold_ok = prev_q && !err_q && req_g && (hold_q < HOLD_LIM);
    assign gsel    = hold_ok ? grant_q : win;

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        wen_sel   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (3'(i) == gsel) begin
                addr_sel  = ch_addr[i*ADDR_W +: ADDR_W];
                wdata_sel = ch_wdata[i*8 +: 8];
                wen_sel   = ch_wen[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        wait_d      = wait_q;
        err_d       = err_q;
        prev_d      = prev_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = mem_wen_q;
        ch_ack_d    = '0;
        ch_err_d    = '0;
        ch_rdata_d  = '0;
        unique case (state_q)
            ARB: begin
                if (|ch_req) begin
                    hold_d      = hold_ok ? hold_q + 1'b1 : '0;
                    ptr_d       = (PRIO_MODE == 0) ? gsel : ptr_q;
                    grant_d     = gsel;
                    prev_d      = 1'b1;
                    err_d       = 1'b0;
                    wait_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = addr_sel;
                    mem_wdata_d = wdata_sel;
                    mem_wen_d   = wen_sel;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    ch_ack_d   = gmask;
                    ch_rdata_d = mem_wen_q ? 8'h00 : mem_rdata[7:0];
                    state_d    = DONE;
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    mem_req_d = 1'b0;
                    ch_ack_d  = gmask;
                    ch_err_d  = gmask;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= 3'(NCH - 1);
            grant_q     <= '0;
            hold_q      <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            prev_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            ch_ack_q    <= '0;
            ch_err_q    <= '0;
            ch_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            prev_q      <= prev_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            ch_ack_q    <= ch_ack_d;
            ch_err_q    <= ch_err_d;
            ch_rdata_q  <= ch_rdata_d;
        end
    end

    assign ch_rdata  = ch_rdata_q;
    assign ch_ack    = ch_ack_q;
    assign ch_err    = ch_err_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = {56'h0, mem_wdata_q};
    assign mem_wen   = mem_wen_q;
    assign mem_size  = 2'b00;
    assign busy      = (state_q != ARB);
    assign grant_id  = grant_q;

endmodule

// File: doc/mp64_dma_arb.md
Name: mp64_dma_arb

Overview:
Parametrised N-channel DMA arbiter that merges byte-wide peripheral DMA masters onto one 64-bit memory request port. Disk, NIC and future DMA engines connect here instead of to fixed ack stubs. The arbiter output drives the memory controller's DMA-side port.
- Round-robin or fixed-priority arbitration.
- Optional per-grant hold, which keeps the bus with one channel across short bursts.
- Per-transfer timeout with error reporting.

Parameters:
NCH, 2, number of DMA channels (1..8)
ADDR_W, 64, address width per channel and at the memory port
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
HOLD, 1, maximum consecutive grants to one channel while it keeps requesting (1 = no hold)
TIMEOUT, 256, cycles to wait for mem_ack before aborting (0 = disabled)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ch_req  in  NCH  per-channel request, level; held until that channel's ack
ch_addr  in  NCH*ADDR_W  flattened byte addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NCH*8  flattened write bytes
ch_wen  in  NCH  1 = write, 0 = read
ch_rdata  out  8  read byte, valid only with ch_ack
ch_ack  out  NCH  one-cycle completion pulse, one-hot
ch_err  out  NCH  one-cycle timeout pulse, coincident with ch_ack
mem_req  out  1  memory request
mem_addr  out  ADDR_W  memory address
mem_wdata  out  64  write data: byte in [7:0], upper bits zero
mem_wen  out  1  write enable
mem_size  out  2  always 2'b00 (byte)
mem_rdata  in  64  read data; byte taken from [7:0]
mem_ack  in  1  memory completion, single cycle
busy  out  1  high in any state other than ARB
grant_id  out  3  index of the channel currently or last granted

Behaviour:
Reset values (a synchronous rst dominates every other input):
- All outputs are 0.
- State = ARB.
- Round-robin pointer = NCH-1, so channel 0 wins first.
- Hold and timeout counters = 0.

State machine, three states:
- ARB:
  - If no ch_req is set, stay in ARB.
  - Otherwise pick a winner g and register ch_addr/ch_wdata/ch_wen[g] into the mem_* outputs.
  - Set grant_id = g and go to ISSUE.
- ISSUE:
  - mem_req = 1; mem_addr, mem_wdata and mem_wen are held stable.
  - On mem_ack (checked in ISSUE, including the first ISSUE cycle): capture mem_rdata[7:0], drop mem_req and go to DONE.
  - If TIMEOUT != 0 and the wait counter reaches TIMEOUT-1 with no ack: drop mem_req, set error, go to DONE.
- DONE:
  - ch_ack[g] = 1 for one cycle; ch_err[g] = error.
  - ch_rdata = captured byte, or 0 on timeout (0 for writes as well).
  - Go to ARB.

Minimum latency: request sampled in ARB at cycle 0, mem_req high in cycle 1, ch_ack in cycle 2 if mem_ack arrives in cycle 1, next ARB in cycle 3. Channels update or drop req on the edge ending their ack cycle.

Winner selection:
- Round-robin: search indices pointer+1, pointer+2, … modulo NCH. The first asserted request wins and the pointer is set to the winner.
- Fixed priority: the lowest asserted index wins. The pointer is not used.

Hold:
- In ARB, if the previous winner still asserts req and hold_cnt < HOLD-1, regrant it regardless of mode and increment hold_cnt.
- Otherwise arbitrate normally and set hold_cnt = 0.
- If a timeout occurred, the hold is not applied.

Boundary conditions:
- A req that drops while the channel is granted is ignored; the transfer completes, and the bench treats this as a protocol violation.
- mem_ack outside ISSUE is ignored.
- The counter saturates and never wraps.
- NCH = 1: grant is always channel 0.
- rst asserted in ISSUE: mem_req = 0 on the next cycle and no ch_ack is issued.

Test Plan:
1. Single read: ch_req = 01, ch_addr0 = 0x100, mem_ack in the first ISSUE cycle with mem_rdata = 0x…A5 -> mem_addr = 0x100, mem_size = 0, ch_ack = 01 two cycles after the request, ch_rdata = 0xA5.
2. Round-robin: NCH = 2, both channels request continuously, mem_ack immediate, HOLD = 1 -> grant order 0,1,0,1; each ack spaced 3 cycles apart.
3. Fixed priority: PRIO_MODE = 1, ch_req = 11 for 4 transfers -> all 4 grants go to channel 0; channel 1 is granted after channel 0 drops req.
4. Hold: HOLD = 3, both channels always requesting -> grant sequence 0,0,0,1,1,1,0.
5. Timeout: TIMEOUT = 8, mem_ack never asserted -> mem_req high for exactly 8 cycles, then ch_ack and ch_err pulse together with ch_rdata = 0; the next channel is then granted.
6. Reset mid-transfer: rst in the second ISSUE cycle -> mem_req = 0 on the next cycle, no ch_ack, and the first grant after reset goes to channel 0.
